exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//  Execute stage of the 5-stage ARM pipeline; consumes the ID/EX pipeline register outputs.
//  - Forms the second operand (Val2).
//  - Runs the ALU.
//  - Computes the branch target.
//  - Owns the architectural NZCV status register.
//  - ALU_Res, Br_addr and SR feed the EX/MEM register, the IF stage and the ID condition check.
// PARAMETERS
//  DW      32  datapath width; only 32 is supported
// PORTS
//  clk            in   1   rising-edge clock, single clock domain
//  rst            in   1   synchronous, active-high reset
//  EXE_CMD        in   4   ALU opcode, encoded in the shared package
//  MEM_R_EN       in   1   load; selects offset12 for Val2
//  MEM_W_EN       in   1   store; selects offset12 for Val2
//  S              in   1   update SR at the end of this cycle
//  PC             in   32  PC+4 of the instruction
//  Val_Rn         in   32  first operand
//  Val_Rm         in   32  register operand for the shifter
//  imm            in   1   I bit
//  Shift_operand  in   12  instr[11:0]
//  Signed_imm_24  in   24  branch offset in words
//  ALU_Res        out  32  ALU result, or address for LDR/STR
//  Br_addr        out  32  PC + (sext(Signed_imm_24) << 2)
//  SR             out  4   registered {N,Z,C,V}
// BEHAVIOUR
//  - Reset:
//    - SR = 4'b0000 on the clk edge where rst=1.
//    - ALU_Res and Br_addr are combinational and need no reset value.
//  - Latency:
//    - ALU_Res and Br_addr are combinational in the same cycle as the inputs.
//    - SR updates on the edge ending that cycle; the new flags are visible next cycle.
//  - Val2 selection, highest priority first:
//    1. MEM_R_EN|MEM_W_EN: {20'b0, Shift_operand[11:0]}.
//    2. imm=1: {24'b0, Shift_operand[7:0]} rotated right by 2*Shift_operand[11:8].
//    3. else: Val_Rm shifted by shift_imm=Shift_operand[11:7], with type Shift_operand[6:5]:
//       00 LSL, 01 LSR, 10 ASR, 11 ROR.
//    - Shift amount 0 passes Val_Rm unchanged for all four types; RRX is not supported.
//  - ALU ops; Cin = SR.C as registered:
//    0001 MOV  r=Val2
//    1001 MVN  r=~Val2
//    0010 ADD  r=Rn+Val2
//    0011 ADC  r=Rn+Val2+Cin
//    0100 SUB  r=Rn-Val2
//    0101 SBC  r=Rn-Val2-!Cin
//    0110 AND  r=Rn&Val2
//    0111 ORR  r=Rn|Val2
//    1000 EOR  r=Rn^Val2
//    other     r=0, flags unchanged
//  - CMP maps to SUB and TST maps to AND; LDR/STR use ADD.
//  - Flags:
//    - N=r[31]; Z=(r==0).
//    - Arithmetic is done 33 bits wide.
//    - ADD/ADC: C=bit32; V=(Rn[31]==Val2[31]) && (r[31]!=Rn[31]).
//    - SUB/SBC: C=NOT borrow, so 1 when no borrow; V=(Rn[31]!=Val2[31]) && (r[31]!=Rn[31]).
//    - Logic ops, MOV, MVN: C and V keep their current SR values.
//  - SR write:
//    - On the posedge with rst=0 and S=1, SR <= {N,Z,C,V}; otherwise SR holds.
//    - Flushed or bubble instructions arrive with S=0 from ID/EX and never touch SR.
//  - Simultaneous events: rst=1 with S=1 gives SR=0; reset wins.
//  - ADC/SBC followed back-to-back by a flag-setting op: the second op uses the SR written
//    by the first, because the first op's SR update lands on the edge between them.
// STRUCTURE
//  - Shared package: EXE_CMD opcode localparams; shift-type codes (LSL/LSR/ASR/ROR); SR bit indices.
//  - Sub-modules, plus a combinational ALU inline or in its own file:
//    - val2_gen: combinational shifter/rotator.
//    - status_reg: 4-bit register with sync reset and load enable.
// TESTING
//  1. Reset: rst=1 for 2 cycles with S=1 and Val_Rn=0 -> SR==0000 throughout; after rst=0 a
//     MOV of 0 with S=1 gives SR==0100.
//  2. Rotate immediate: imm=1, Shift_operand=12'h4FF, MOV -> ALU_Res==32'hFF000000 (0xFF ror 8).
//  3. Shifts with Val_Rm=32'h80000001:
//     - ASR 4, MOV -> 32'hF8000000.
//     - ROR 1 -> 32'hC0000000.
//     - LSL 0 -> 32'h80000001.
//  4. Add overflow: ADD, Rn=32'h7FFFFFFF, Val2=1, S=1 -> ALU_Res=32'h80000000; next cycle SR==1001.
//  5. Carry chain:
//     - SUB, Rn=5, Val2=5, S=1 -> SR==0110.
//     - Then SBC, Rn=0, Val2=0, S=1 -> r=0, SR==0110.
//     - Then repeat with SR.C=0 -> r=32'hFFFFFFFF, SR==1000.
//  6. Branch and memory address:
//     - PC=32'h100, Signed_imm_24=24'hFFFFFE -> Br_addr==32'hF8.
//     - MEM_R_EN=1, ADD, Rn=32'h400, Shift_operand=12'h8FC -> ALU_Res==32'hCFC; SR unchanged with S=0.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// rtl/exe_stage_pkg.sv - shared execute-stage opcodes, shift types and status bit indices
package exe_stage_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

endpackage

// File: rtl/exe_stage_status_reg.sv
// rtl/exe_stage_status_reg.sv - NZCV status register with sync reset and load enable
module exe_stage_status_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_i,
  input  logic [3:0] sr_d_i,
  output logic [3:0] sr_q_o
);

  logic [3:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= 4'b0000;
    end else if (ld_i) begin
      sr_q <= sr_d_i;
    end
  end

  assign sr_q_o = sr_q;

endmodule

// File: rtl/exe_stage_val2_gen.sv
// rtl/exe_stage_val2_gen.sv - second-operand former: offset12, rotated immediate or shifted register
module exe_stage_val2_gen
  import exe_stage_pkg::*;
(
  input  logic        mem_en_i,
  input  logic        imm_i,
  input  logic [11:0] shift_operand_i,
  input  logic [31:0] val_rm_i,
  output logic [31:0] val2_o
);

  logic [31:0] imm32;
  logic [4:0]  rot_amt;
  logic [4:0]  sh_amt;

  assign imm32   = {24'b0, shift_operand_i[7:0]};
  assign rot_amt = {shift_operand_i[11:8], 1'b0};
  assign sh_amt  = shift_operand_i[11:7];

  // A shift by 32 yields zero, so amount 0 makes both rotates pass the value through.
  always_comb begin
    val2_o = '0;
    if (mem_en_i) begin
      val2_o = {20'b0, shift_operand_i};
    end else if (imm_i) begin
      val2_o = (imm32 >> rot_amt) | (imm32 << (6'd32 - {1'b0, rot_amt}));
    end else begin
      case (shift_operand_i[6:5])
        SH_LSL:  val2_o = val_rm_i << sh_amt;
        SH_LSR:  val2_o = val_rm_i >> sh_amt;
        SH_ASR:  val2_o = 32'($signed(val_rm_i) >>> sh_amt);
        default: val2_o = (val_rm_i >> sh_amt) | (val_rm_i << (6'd32 - {1'b0, sh_amt}));
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - execute stage: Val2, ALU, branch target and architectural NZCV
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    EXE_CMD,
  input  logic          MEM_R_EN,
  input  logic          MEM_W_EN,
  input  logic          S,
  input  logic [DW-1:0] PC,
  input  logic [DW-1:0] Val_Rn,
  input  logic [DW-1:0] Val_Rm,
  input  logic          imm,
  input  logic [11:0]   Shift_operand,
  input  logic [23:0]   Signed_imm_24,
  output logic [DW-1:0] ALU_Res,
  output logic [DW-1:0] Br_addr,
  output logic [3:0]    SR
);

  logic [DW-1:0] val2;
  logic [DW:0]   sum;
  logic [DW-1:0] r;
  logic          c_flag;
  logic          v_flag;
  logic          op_valid;
  logic          cin;
  logic [3:0]    sr_d;

  exe_stage_val2_gen u_val2_gen (
    .mem_en_i        (MEM_R_EN | MEM_W_EN),
    .imm_i           (imm),
    .shift_operand_i (Shift_operand),
    .val_rm_i        (Val_Rm),
    .val2_o          (val2)
  );

  assign cin = SR[SR_C];

  always_comb begin
    sum      = '0;
    r        = '0;
    c_flag   = SR[SR_C];
    v_flag   = SR[SR_V];
    op_valid = 1'b1;
    case (EXE_CMD)
      CMD_MOV: r = val2;
      CMD_MVN: r = ~val2;
      CMD_ADD, CMD_ADC: begin
        sum    = {1'b0, Val_Rn} + {1'b0, val2} + {{DW{1'b0}}, (EXE_CMD == CMD_ADC) & cin};
        r      = sum[DW-1:0];
        c_flag = sum[DW];
        v_flag = (Val_Rn[DW-1] == val2[DW-1]) && (r[DW-1] != Val_Rn[DW-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // sum[DW] is the borrow; the ARM carry is its inverse.
        sum    = {1'b0, Val_Rn} - {1'b0, val2} - {{DW{1'b0}}, (EXE_CMD == CMD_SBC) & ~cin};
        r      = sum[DW-1:0];
        c_flag = ~sum[DW];
        v_flag = (Val_Rn[DW-1] != val2[DW-1]) && (r[DW-1] != Val_Rn[DW-1]);
      end
      CMD_AND: r = Val_Rn & val2;
      CMD_ORR: r = Val_Rn | val2;
      CMD_EOR: r = Val_Rn ^ val2;
      default: op_valid = 1'b0;
    endcase
  end

  assign sr_d    = op_valid ? {r[DW-1], (r == '0), c_flag, v_flag} : SR;
  assign ALU_Res = r;
  assign Br_addr = PC + {{(DW-26){Signed_imm_24[23]}}, Signed_imm_24, 2'b00};

  exe_stage_status_reg u_status_reg (
    .clk    (clk),
    .rst    (rst),
    .ld_i   (S),
    .sr_d_i (sr_d),
    .sr_q_o (SR)
  );

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - directed self-checking bench for exe_stage
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  EXE_CMD;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic        S;
  logic [31:0] PC;
  logic [31:0] Val_Rn;
  logic [31:0] Val_Rm;
  logic        imm;
  logic [11:0] Shift_operand;
  logic [23:0] Signed_imm_24;
  logic [31:0] ALU_Res;
  logic [31:0] Br_addr;
  logic [3:0]  SR;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  exe_stage #(.DW(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .EXE_CMD       (EXE_CMD),
    .MEM_R_EN      (MEM_R_EN),
    .MEM_W_EN      (MEM_W_EN),
    .S             (S),
    .PC            (PC),
    .Val_Rn        (Val_Rn),
    .Val_Rm        (Val_Rm),
    .imm           (imm),
    .Shift_operand (Shift_operand),
    .Signed_imm_24 (Signed_imm_24),
    .ALU_Res       (ALU_Res),
    .Br_addr       (Br_addr),
    .SR            (SR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0] cmd, input logic s_i, input logic [31:0] rn,
                    input logic [31:0] rm, input logic imm_i, input logic [11:0] so);
    EXE_CMD       = cmd;
    S             = s_i;
    Val_Rn        = rn;
    Val_Rm        = rm;
    imm           = imm_i;
    Shift_operand = so;
    MEM_R_EN      = 1'b0;
    MEM_W_EN      = 1'b0;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    PC = 32'h0;
    Signed_imm_24 = 24'h0;
    @(negedge clk);
    op(4'b0001, 1'b1, 32'h0, 32'h0, 1'b1, 12'h000);
    tick();
    chk("reset_sr_1", {28'b0, SR}, 32'h0);
    tick();
    chk("reset_sr_2", {28'b0, SR}, 32'h0);
    rst = 1'b0;
    op(4'b0001, 1'b1, 32'h0, 32'h0, 1'b1, 12'h000);
    chk("mov0_res", ALU_Res, 32'h0);
    tick();
    chk("mov0_sr", {28'b0, SR}, 32'h4);

    op(4'b0001, 1'b0, 32'h0, 32'h0, 1'b1, 12'h4FF);
    chk("rot_imm", ALU_Res, 32'hFF000000);
    op(4'b0001, 1'b0, 32'h0, 32'h80000001, 1'b0, 12'h240);
    chk("asr4", ALU_Res, 32'hF8000000);
    op(4'b0001, 1'b0, 32'h0, 32'h80000001, 1'b0, 12'h0E0);
    chk("ror1", ALU_Res, 32'hC0000000);
    op(4'b0001, 1'b0, 32'h0, 32'h80000001, 1'b0, 12'h000);
    chk("lsl0", ALU_Res, 32'h80000001);
    op(4'b0001, 1'b0, 32'h0, 32'h80000001, 1'b0, 12'h220);
    chk("lsr4", ALU_Res, 32'h08000000);
    op(4'b0001, 1'b0, 32'h0, 32'h80000001, 1'b0, 12'h060);
    chk("ror0", ALU_Res, 32'h80000001);
    tick();
    chk("no_s_hold", {28'b0, SR}, 32'h4);

    op(4'b1001, 1'b1, 32'h0, 32'h0, 1'b1, 12'h000);
    chk("mvn_res", ALU_Res, 32'hFFFFFFFF);
    tick();
    chk("mvn_sr", {28'b0, SR}, 32'h8);

    op(4'b0010, 1'b1, 32'h7FFFFFFF, 32'h0, 1'b1, 12'h001);
    chk("add_ovf_res", ALU_Res, 32'h80000000);
    tick();
    chk("add_ovf_sr", {28'b0, SR}, 32'h9);

    op(4'b0100, 1'b1, 32'h5, 32'h0, 1'b1, 12'h005);
    chk("sub_res", ALU_Res, 32'h0);
    tick();
    chk("sub_sr", {28'b0, SR}, 32'h6);
    op(4'b0101, 1'b1, 32'h0, 32'h0, 1'b1, 12'h000);
    chk("sbc_c1_res", ALU_Res, 32'h0);
    tick();
    chk("sbc_c1_sr", {28'b0, SR}, 32'h6);
    op(4'b1111, 1'b1, 32'h12345678, 32'h0, 1'b1, 12'h0FF);
    chk("undef_res", ALU_Res, 32'h0);
    tick();
    chk("undef_sr", {28'b0, SR}, 32'h6);
    op(4'b0010, 1'b1, 32'h1, 32'h0, 1'b1, 12'h001);
    chk("add_res", ALU_Res, 32'h2);
    tick();
    chk("add_sr", {28'b0, SR}, 32'h0);
    op(4'b0101, 1'b1, 32'h0, 32'h0, 1'b1, 12'h000);
    chk("sbc_c0_res", ALU_Res, 32'hFFFFFFFF);
    tick();
    chk("sbc_c0_sr", {28'b0, SR}, 32'h8);

    op(4'b0011, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b1, 12'h001);
    chk("adc_c0_res", ALU_Res, 32'h0);
    tick();
    chk("adc_c0_sr", {28'b0, SR}, 32'h6);
    op(4'b0110, 1'b1, 32'hF0, 32'h0, 1'b1, 12'h00F);
    chk("and_res", ALU_Res, 32'h0);
    tick();
    chk("and_keeps_c", {28'b0, SR}, 32'h6);
    op(4'b0011, 1'b1, 32'h1, 32'h0, 1'b1, 12'h001);
    chk("adc_c1_res", ALU_Res, 32'h3);
    tick();
    chk("adc_c1_sr", {28'b0, SR}, 32'h0);

    op(4'b1000, 1'b0, 32'hFF, 32'h0, 1'b1, 12'h00F);
    chk("eor_res", ALU_Res, 32'hF0);
    op(4'b0111, 1'b0, 32'hF0, 32'h0, 1'b1, 12'h00F);
    chk("orr_res", ALU_Res, 32'hFF);

    PC = 32'h100;
    Signed_imm_24 = 24'hFFFFFE;
    #1;
    chk("br_neg", Br_addr, 32'hF8);
    PC = 32'h0;
    Signed_imm_24 = 24'h000003;
    #1;
    chk("br_pos", Br_addr, 32'hC);

    op(4'b0010, 1'b0, 32'h400, 32'hFFFFFFFF, 1'b0, 12'h8FC);
    MEM_R_EN = 1'b1;
    #1;
    chk("ldr_addr", ALU_Res, 32'hCFC);
    tick();
    chk("ldr_sr_hold", {28'b0, SR}, 32'h0);
    op(4'b0010, 1'b0, 32'h400, 32'h0, 1'b1, 12'h8FC);
    MEM_W_EN = 1'b1;
    #1;
    chk("str_addr", ALU_Res, 32'hCFC);

    op(4'b1001, 1'b1, 32'h0, 32'h0, 1'b1, 12'h000);
    tick();
    chk("pre_rst_sr", {28'b0, SR}, 32'h8);
    rst = 1'b1;
    tick();
    chk("rst_beats_s", {28'b0, SR}, 32'h0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
